// File: rtl/mem_bus_responder.sv
// mem_bus_responder: byte-serial bus slave that assembles 32-bit words and issues single memory requests.
module mem_bus_responder #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sync,
   input  logic        rw,
   input  logic [7:0]  addr_in,
   input  logic [7:0]  wdata_in,
   output logic [7:0]  rdata_out,
   output logic        rdata_oe,
   output logic        rdy,
   output logic        err,
   input  logic        clr_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);
   typedef enum logic [1:0] {IDLE, ADDR, MEM, DATA} state_t;
   state_t      state_q;
   logic [1:0]  beat_q;
   logic [1:0]  beat_nx;
   logic        rw_q;
   logic [7:0]  cnt_q;
   logic [31:0] rdata_q;
   logic [31:0] word_d;
   logic [7:0]  rout_q;
   logic        oe_q, rdy_q, err_q, err_d, req_q, we_q;
   logic [31:0] addr_q, wdata_q;
   logic        abort, tmo;
   assign abort   = sync && state_q != IDLE;
   // an ack in the final allowed cycle wins over the timeout
   assign tmo     = state_q == MEM && !mem_ack && cnt_q == 8'(TIMEOUT - 1);
   assign beat_nx = beat_q + 2'd1;
   always_comb begin
      word_d = mem_ack ? mem_rdata : 32'hFFFF_FFFF;
      err_d  = (abort || tmo) ? 1'b1 : clr_err ? 1'b0 : err_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         beat_q  <= '0;
         rw_q    <= 1'b0;
         cnt_q   <= '0;
         rdata_q <= '0;
         rout_q  <= '0;
         oe_q    <= 1'b0;
         rdy_q   <= 1'b0;
         err_q   <= 1'b0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         err_q <= err_d;
         rdy_q <= 1'b0;
         if (abort) begin
            state_q <= ADDR;
            beat_q  <= '0;
            rw_q    <= rw;
            req_q   <= 1'b0;
            oe_q    <= 1'b0;
            rout_q  <= '0;
         end else begin
            case (state_q)
               IDLE: if (sync) begin
                  state_q <= ADDR;
                  beat_q  <= '0;
                  rw_q    <= rw;
               end
               ADDR: begin
                  addr_q[{beat_q, 3'b000} +: 8]  <= addr_in;
                  wdata_q[{beat_q, 3'b000} +: 8] <= wdata_in;
                  beat_q <= beat_nx;
                  if (beat_q == 2'd3) begin
                     state_q <= MEM;
                     req_q   <= 1'b1;
                     we_q    <= ~rw_q;
                     cnt_q   <= '0;
                  end
               end
               MEM: if (mem_ack || tmo) begin
                  req_q <= 1'b0;
                  rdy_q <= 1'b1;
                  if (rw_q) begin
                     state_q <= DATA;
                     beat_q  <= '0;
                     rdata_q <= word_d;
                     oe_q    <= 1'b1;
                     rout_q  <= word_d[7:0];
                  end else begin
                     state_q <= IDLE;
                  end
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
               DATA: begin
                  beat_q <= beat_nx;
                  if (beat_q == 2'd3) begin
                     state_q <= IDLE;
                     oe_q    <= 1'b0;
                     rout_q  <= '0;
                  end else begin
                     rout_q <= rdata_q[{beat_nx, 3'b000} +: 8];
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end
   assign rdata_out = rout_q;
   assign rdata_oe  = oe_q;
   assign rdy       = rdy_q;
   assign err       = err_q;
   assign mem_req   = req_q;
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
endmodule

// File: tb/tb_mem_bus_responder.sv
// tb_mem_bus_responder: directed checks of read, write, timeout, abort and reset behaviour.
module tb_mem_bus_responder;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sync = 1'b0, rw = 1'b0, clr_err = 1'b0, mem_ack = 1'b0;
   logic [7:0]  addr_in = '0, wdata_in = '0;
   logic [31:0] mem_rdata = '0;
   logic [7:0]  rdata_out;
   logic        rdata_oe, rdy, err, mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   int          n_cmp = 0, n_err = 0;
   logic [31:0] exp_word;

   mem_bus_responder #(.TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n), .sync(sync), .rw(rw),
      .addr_in(addr_in), .wdata_in(wdata_in),
      .rdata_out(rdata_out), .rdata_oe(rdata_oe), .rdy(rdy), .err(err),
      .clr_err(clr_err), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // sync in the current cycle, then four address/data beats; returns in the first MEM cycle
   task automatic send(input logic r, input logic [31:0] a, input logic [31:0] w);
      sync = 1'b1;
      rw   = r;
      tick();
      sync = 1'b0;
      for (int k = 0; k < 4; k++) begin
         addr_in  = a[8*k +: 8];
         wdata_in = w[8*k +: 8];
         tick();
      end
      addr_in  = '0;
      wdata_in = '0;
   endtask

   initial begin
      tick();
      tick();
      chk("rst_req", {31'b0, mem_req}, 32'd0);
      chk("rst_oe", {31'b0, rdata_oe}, 32'd0);
      chk("rst_rdy", {31'b0, rdy}, 32'd0);
      chk("rst_err", {31'b0, err}, 32'd0);
      chk("rst_we", {31'b0, mem_we}, 32'd0);
      chk("rst_rout", {24'b0, rdata_out}, 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      rst_n = 1'b1;
      tick();

      // read frame, ack in the first MEM cycle
      send(1'b1, 32'h1234_5678, 32'h0);
      chk("rd_req", {31'b0, mem_req}, 32'd1);
      chk("rd_we", {31'b0, mem_we}, 32'd0);
      chk("rd_addr", mem_addr, 32'h1234_5678);
      chk("rd_rdy_early", {31'b0, rdy}, 32'd0);
      mem_ack   = 1'b1;
      mem_rdata = 32'hDDCC_BBAA;
      tick();
      mem_ack   = 1'b0;
      mem_rdata = '0;
      chk("rd_req_drop", {31'b0, mem_req}, 32'd0);
      chk("rd_rdy", {31'b0, rdy}, 32'd1);
      exp_word = 32'hDDCC_BBAA;
      for (int k = 0; k < 4; k++) begin
         chk("rd_oe", {31'b0, rdata_oe}, 32'd1);
         chk("rd_byte", {24'b0, rdata_out}, {24'b0, exp_word[8*k +: 8]});
         if (k > 0) chk("rd_rdy_once", {31'b0, rdy}, 32'd0);
         tick();
      end
      chk("rd_oe_end", {31'b0, rdata_oe}, 32'd0);
      chk("rd_rout_end", {24'b0, rdata_out}, 32'd0);
      chk("rd_err", {31'b0, err}, 32'd0);

      // write frame, ack in the third MEM cycle
      send(1'b0, 32'h0000_0004, 32'hDEAD_BEEF);
      chk("wr_req0", {31'b0, mem_req}, 32'd1);
      chk("wr_we", {31'b0, mem_we}, 32'd1);
      chk("wr_addr", mem_addr, 32'h0000_0004);
      chk("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
      tick();
      chk("wr_req1", {31'b0, mem_req}, 32'd1);
      chk("wr_rdy1", {31'b0, rdy}, 32'd0);
      tick();
      chk("wr_req2", {31'b0, mem_req}, 32'd1);
      chk("wr_wdata_hold", mem_wdata, 32'hDEAD_BEEF);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk("wr_req_drop", {31'b0, mem_req}, 32'd0);
      chk("wr_rdy", {31'b0, rdy}, 32'd1);
      chk("wr_oe", {31'b0, rdata_oe}, 32'd0);
      tick();
      chk("wr_rdy_once", {31'b0, rdy}, 32'd0);
      chk("wr_oe2", {31'b0, rdata_oe}, 32'd0);

      // read timeout with clr_err in the timeout cycle; late ack ignored
      send(1'b1, 32'h0000_0100, 32'h0);
      for (int k = 0; k < 15; k++) tick();
      chk("to_req_last", {31'b0, mem_req}, 32'd1);
      chk("to_err_before", {31'b0, err}, 32'd0);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      chk("to_req_drop", {31'b0, mem_req}, 32'd0);
      chk("to_err_set_wins", {31'b0, err}, 32'd1);
      chk("to_rdy", {31'b0, rdy}, 32'd1);
      chk("to_oe", {31'b0, rdata_oe}, 32'd1);
      chk("to_byte0", {24'b0, rdata_out}, 32'h0000_00FF);
      tick();
      chk("to_byte1", {24'b0, rdata_out}, 32'h0000_00FF);
      tick();
      chk("to_byte2", {24'b0, rdata_out}, 32'h0000_00FF);
      mem_ack   = 1'b1;
      mem_rdata = 32'h1234_5678;
      tick();
      mem_ack   = 1'b0;
      mem_rdata = '0;
      chk("to_byte3", {24'b0, rdata_out}, 32'h0000_00FF);
      chk("to_late_req", {31'b0, mem_req}, 32'd0);
      tick();
      chk("to_oe_end", {31'b0, rdata_oe}, 32'd0);
      chk("to_rdy_end", {31'b0, rdy}, 32'd0);
      chk("to_err_held", {31'b0, err}, 32'd1);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      chk("clr_err", {31'b0, err}, 32'd0);

      // ack in the same cycle the timeout would fire
      send(1'b0, 32'h0000_0010, 32'hCAFE_F00D);
      for (int k = 0; k < 15; k++) tick();
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk("ackto_err", {31'b0, err}, 32'd0);
      chk("ackto_rdy", {31'b0, rdy}, 32'd1);
      chk("ackto_req", {31'b0, mem_req}, 32'd0);

      // abort at ADDR beat 2, new write frame follows
      sync = 1'b1;
      rw   = 1'b1;
      tick();
      sync = 1'b0;
      addr_in = 8'h11;
      tick();
      addr_in = 8'h22;
      tick();
      sync    = 1'b1;
      rw      = 1'b0;
      addr_in = 8'h33;
      tick();
      sync = 1'b0;
      chk("ab_err", {31'b0, err}, 32'd1);
      chk("ab_req", {31'b0, mem_req}, 32'd0);
      chk("ab_rdy", {31'b0, rdy}, 32'd0);
      exp_word = 32'hA0A1_A2A3;
      for (int k = 0; k < 4; k++) begin
         addr_in  = exp_word[8*k +: 8];
         wdata_in = 8'(k + 1);
         chk("ab_no_req", {31'b0, mem_req}, 32'd0);
         tick();
      end
      addr_in  = '0;
      wdata_in = '0;
      chk("ab_req_new", {31'b0, mem_req}, 32'd1);
      chk("ab_addr", mem_addr, 32'hA0A1_A2A3);
      chk("ab_wdata", mem_wdata, 32'h0403_0201);
      chk("ab_we", {31'b0, mem_we}, 32'd1);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk("ab_rdy_new", {31'b0, rdy}, 32'd1);
      chk("ab_req_done", {31'b0, mem_req}, 32'd0);
      tick();
      chk("ab_req_once", {31'b0, mem_req}, 32'd0);

      // asynchronous reset during MEM
      send(1'b1, 32'h0000_0055, 32'h0);
      chk("rs_req_pre", {31'b0, mem_req}, 32'd1);
      chk("rs_err_pre", {31'b0, err}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rs_req_async", {31'b0, mem_req}, 32'd0);
      chk("rs_err_async", {31'b0, err}, 32'd0);
      chk("rs_addr_async", mem_addr, 32'd0);
      @(posedge clk);
      #3;
      rst_n   = 1'b1;
      mem_ack = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("rs_no_rdy", {31'b0, rdy}, 32'd0);
         chk("rs_no_oe", {31'b0, rdata_oe}, 32'd0);
         chk("rs_no_req", {31'b0, mem_req}, 32'd0);
      end
      mem_ack = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
